// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - stage/butterfly walker and RAM/twiddle address generator for an in-place radix-2 DIT FFT
module fft_stage_sequencer #(
  parameter int LOG2_N       = 4,
  parameter int BFLY_LATENCY = 2
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [LOG2_N-1:0] o_stage,
  output logic              o_rd_en,
  output logic [LOG2_N-1:0] o_rd_addr_A,
  output logic [LOG2_N-1:0] o_rd_addr_B,
  output logic [LOG2_N-2:0] o_tw_addr,
  output logic              o_bf_valid,
  output logic              o_wr_en,
  output logic [LOG2_N-1:0] o_wr_addr_A,
  output logic [LOG2_N-1:0] o_wr_addr_B
);

  localparam int L  = 1 + BFLY_LATENCY;
  localparam int KW = LOG2_N - 1;
  localparam int DW = $clog2(L + 1);
  localparam logic [DW-1:0]     L_CNT      = DW'(L);
  localparam logic [LOG2_N-1:0] LAST_STAGE = LOG2_N'(LOG2_N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t            state;
  logic [KW-1:0]     k;
  logic [DW-1:0]     dcnt;

  logic              issue_go;
  logic [LOG2_N-1:0] issue_s;
  logic [KW-1:0]     issue_k;

  logic [L-1:0]      dl_valid;
  logic [LOG2_N-1:0] dl_a [L];
  logic [LOG2_N-1:0] dl_b [L];

  // A = (k >> s) * 2^(s+1) + (k mod 2^s); B sets the 2^s bit of A.
  function automatic logic [LOG2_N-1:0] calc_a(input logic [LOG2_N-1:0] s, input logic [KW-1:0] kin);
    logic [LOG2_N-1:0] kk;
    logic [LOG2_N-1:0] mask;
    kk     = {1'b0, kin};
    mask   = (LOG2_N'(1) << s) - LOG2_N'(1);
    calc_a = ((kk >> s) << (s + LOG2_N'(1))) | (kk & mask);
  endfunction

  function automatic logic [KW-1:0] calc_tw(input logic [LOG2_N-1:0] s, input logic [KW-1:0] kin);
    logic [LOG2_N-1:0] kk;
    logic [LOG2_N-1:0] mask;
    logic [LOG2_N-1:0] tw;
    kk      = {1'b0, kin};
    mask    = (LOG2_N'(1) << s) - LOG2_N'(1);
    tw      = (kk & mask) << (LOG2_N'(LOG2_N - 1) - s);
    calc_tw = tw[KW-1:0];
  endfunction

  // The butterfly to be presented on the read port next cycle, if any.
  always_comb begin
    issue_go = 1'b0;
    issue_s  = '0;
    issue_k  = '0;
    case (state)
      S_IDLE:  issue_go = i_start;
      S_ISSUE: begin
        issue_go = 1'b1;
        issue_s  = o_stage;
        issue_k  = k;
      end
      S_DRAIN: begin
        if (dcnt == L_CNT && o_stage != LAST_STAGE) begin
          issue_go = 1'b1;
          issue_s  = o_stage + LOG2_N'(1);
        end
      end
      default: ;
    endcase
  end

  // The state is already back in IDLE while o_done is high, so a start in
  // the done cycle is accepted without a dead cycle.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state       <= S_IDLE;
      k           <= '0;
      dcnt        <= '0;
      o_stage     <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_rd_en     <= 1'b0;
      o_rd_addr_A <= '0;
      o_rd_addr_B <= '0;
      o_tw_addr   <= '0;
    end else begin
      o_done      <= 1'b0;
      o_rd_en     <= issue_go;
      o_rd_addr_A <= issue_go ? calc_a(issue_s, issue_k) : '0;
      o_rd_addr_B <= issue_go ? (calc_a(issue_s, issue_k) | (LOG2_N'(1) << issue_s)) : '0;
      o_tw_addr   <= issue_go ? calc_tw(issue_s, issue_k) : '0;

      case (state)
        S_IDLE: begin
          if (i_start) begin
            state   <= S_ISSUE;
            o_stage <= '0;
            o_busy  <= 1'b1;
            k       <= KW'(1);
          end
        end
        S_ISSUE: begin
          if (&k) begin
            state <= S_DRAIN;
            dcnt  <= '0;
            k     <= '0;
          end else begin
            k <= k + KW'(1);
          end
        end
        S_DRAIN: begin
          if (dcnt == L_CNT) begin
            if (o_stage == LAST_STAGE) begin
              state   <= S_IDLE;
              o_stage <= '0;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
            end else begin
              state   <= S_ISSUE;
              o_stage <= o_stage + LOG2_N'(1);
              k       <= KW'(1);
            end
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read-to-write-back delay line; addresses are already zero when invalid.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      dl_valid <= '0;
      for (int i = 0; i < L; i++) begin
        dl_a[i] <= '0;
        dl_b[i] <= '0;
      end
    end else begin
      dl_valid[0] <= o_rd_en;
      dl_a[0]     <= o_rd_addr_A;
      dl_b[0]     <= o_rd_addr_B;
      for (int i = 1; i < L; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_a[i]     <= dl_a[i-1];
        dl_b[i]     <= dl_b[i-1];
      end
    end
  end

  assign o_bf_valid  = dl_valid[0];
  assign o_wr_en     = dl_valid[L-1];
  assign o_wr_addr_A = dl_a[L-1];
  assign o_wr_addr_B = dl_b[L-1];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - randomized self-checking bench for fft_stage_sequencer
module tb_fft_stage_sequencer;

  localparam int LOG2_N = 4;
  localparam int BFLY   = 2;
  localparam int N      = 1 << LOG2_N;
  localparam int L      = 1 + BFLY;
  localparam int P      = N / 2 + L;
  localparam int T_LAST = LOG2_N * P;
  localparam int T_DONE = T_LAST + 1;

  logic              clk = 1'b0;
  logic              i_RST;
  logic              i_start;
  logic              o_busy, o_done, o_rd_en, o_bf_valid, o_wr_en;
  logic [LOG2_N-1:0] o_stage, o_rd_addr_A, o_rd_addr_B, o_wr_addr_A, o_wr_addr_B;
  logic [LOG2_N-2:0] o_tw_addr;
  logic [27:0]       all_outs;

  int n_cmp = 0;
  int n_bad = 0;

  logic              e_rd [0:T_DONE+1];
  logic              e_bv [0:T_DONE+1];
  logic              e_wr [0:T_DONE+1];
  logic              e_busy [0:T_DONE+1];
  logic              e_done [0:T_DONE+1];
  logic [LOG2_N-1:0] e_a [0:T_DONE+1];
  logic [LOG2_N-1:0] e_b [0:T_DONE+1];
  logic [LOG2_N-1:0] e_wa [0:T_DONE+1];
  logic [LOG2_N-1:0] e_wb [0:T_DONE+1];
  logic [LOG2_N-1:0] e_stage [0:T_DONE+1];
  logic [LOG2_N-2:0] e_tw [0:T_DONE+1];

  fft_stage_sequencer #(.LOG2_N(LOG2_N), .BFLY_LATENCY(BFLY)) dut (
    .i_CLK(clk), .i_RST(i_RST), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_stage(o_stage),
    .o_rd_en(o_rd_en), .o_rd_addr_A(o_rd_addr_A), .o_rd_addr_B(o_rd_addr_B),
    .o_tw_addr(o_tw_addr), .o_bf_valid(o_bf_valid), .o_wr_en(o_wr_en),
    .o_wr_addr_A(o_wr_addr_A), .o_wr_addr_B(o_wr_addr_B)
  );

  assign all_outs = {o_busy, o_done, o_stage, o_rd_en, o_rd_addr_A, o_rd_addr_B,
                     o_tw_addr, o_bf_valid, o_wr_en, o_wr_addr_A, o_wr_addr_B};

  always #5 clk = ~clk;

  // Expected per-cycle picture of one transform, cycle 0 being the start edge.
  task automatic build_model();
    int c, half, j, g, a;
    for (int t = 0; t <= T_DONE + 1; t++) begin
      e_rd[t] = 0; e_bv[t] = 0; e_wr[t] = 0; e_a[t] = 0; e_b[t] = 0;
      e_wa[t] = 0; e_wb[t] = 0; e_tw[t] = 0;
      e_busy[t]  = (t >= 1 && t <= T_LAST);
      e_done[t]  = (t == T_DONE);
      e_stage[t] = e_busy[t] ? LOG2_N'((t - 1) / P) : '0;
    end
    for (int s = 0; s < LOG2_N; s++) begin
      half = 2 ** s;
      for (int k = 0; k < N / 2; k++) begin
        j = k % half;
        g = k / half;
        a = g * 2 * half + j;
        c = 1 + s * P + k;
        e_rd[c] = 1; e_a[c] = LOG2_N'(a); e_b[c] = LOG2_N'(a + half);
        e_tw[c] = (LOG2_N-1)'(j * (2 ** (LOG2_N - 1 - s)));
        e_bv[c+1] = 1;
        e_wr[c+L] = 1; e_wa[c+L] = LOG2_N'(a); e_wb[c+L] = LOG2_N'(a + half);
      end
    end
  endtask

  task automatic check_transform(input int noise_mode, input bit prestarted, input bit chain);
    int wr_cnt;
    wr_cnt = 0;
    if (!prestarted) begin
      @(negedge clk);
      i_start = 1'b1;
    end
    for (int c = 1; c <= T_DONE; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({o_rd_en, o_rd_addr_A, o_rd_addr_B, o_tw_addr} !== {e_rd[c], e_a[c], e_b[c], e_tw[c]}) begin
        n_bad++;
        $display("FAIL rd cycle %0d: got en=%0d A=%0d B=%0d tw=%0d, want en=%0d A=%0d B=%0d tw=%0d",
                 c, o_rd_en, o_rd_addr_A, o_rd_addr_B, o_tw_addr, e_rd[c], e_a[c], e_b[c], e_tw[c]);
      end
      n_cmp++;
      if (o_bf_valid !== e_bv[c]) begin
        n_bad++;
        $display("FAIL bf_valid cycle %0d: got %0d want %0d", c, o_bf_valid, e_bv[c]);
      end
      n_cmp++;
      if ({o_wr_en, o_wr_addr_A, o_wr_addr_B} !== {e_wr[c], e_wa[c], e_wb[c]}) begin
        n_bad++;
        $display("FAIL wr cycle %0d: got en=%0d A=%0d B=%0d, want en=%0d A=%0d B=%0d",
                 c, o_wr_en, o_wr_addr_A, o_wr_addr_B, e_wr[c], e_wa[c], e_wb[c]);
      end
      n_cmp++;
      if ({o_busy, o_done, o_stage} !== {e_busy[c], e_done[c], e_stage[c]}) begin
        n_bad++;
        $display("FAIL ctl cycle %0d: got busy=%0d done=%0d stage=%0d, want busy=%0d done=%0d stage=%0d",
                 c, o_busy, o_done, o_stage, e_busy[c], e_done[c], e_stage[c]);
      end
      if (o_wr_en === 1'b1) wr_cnt++;
      if (c == T_DONE)       i_start = chain;
      else if (noise_mode == 1) i_start = (c <= 20);
      else if (noise_mode == 2) i_start = 1'($urandom_range(0, 1));
      else                   i_start = 1'b0;
    end
    n_cmp++;
    if (wr_cnt != LOG2_N * N / 2) begin
      n_bad++;
      $display("FAIL wr_count: got %0d want %0d", wr_cnt, LOG2_N * N / 2);
    end
    if (!chain) begin
      @(negedge clk);
      n_cmp++;
      if ({o_busy, o_done, o_rd_en, o_wr_en} !== 4'b0) begin
        n_bad++;
        $display("FAIL post_idle: got busy=%0d done=%0d rd=%0d wr=%0d want all 0",
                 o_busy, o_done, o_rd_en, o_wr_en);
      end
    end
  endtask

  task automatic idle_gap();
    i_start = 1'b0;
    repeat ($urandom_range(1, 5)) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (all_outs !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %h want 0", all_outs);
    end
    i_RST = 1'b1;
    idle_gap();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat ($urandom_range(3, 8)) @(negedge clk);
    @(posedge clk);
    #2 i_RST = 1'b0;
    #1;
    n_cmp++;
    if (all_outs !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got %h want 0", all_outs);
    end
    @(negedge clk);
    i_RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (all_outs !== '0) begin
        n_bad++;
        $display("FAIL reset_hold %0d: got %h want 0", i, all_outs);
      end
    end
  endtask

  task automatic test_spec_points();
    logic [15:0] got;
    idle_gap();
    @(negedge clk);
    i_start = 1'b1;
    for (int c = 1; c <= T_DONE; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      got = {o_rd_en, o_rd_addr_A, o_rd_addr_B, o_tw_addr, o_stage};
      if (c == 1 || c == 2 || c == 28 || c == 41) begin
        n_cmp++;
        case (c)
          1:  if (got !== {1'b1, 4'd0, 4'd1, 3'd0, 4'd0}) begin n_bad++; $display("FAIL spot_c1: got %h", got); end
          2:  if (got !== {1'b1, 4'd2, 4'd3, 3'd0, 4'd0}) begin n_bad++; $display("FAIL spot_c2: got %h", got); end
          28: if (got !== {1'b1, 4'd9, 4'd13, 3'd2, 4'd2}) begin n_bad++; $display("FAIL spot_c28: got %h", got); end
          default: if (got !== {1'b1, 4'd7, 4'd15, 3'd7, 4'd3}) begin n_bad++; $display("FAIL spot_c41: got %h", got); end
        endcase
      end
      if (c == 2) begin
        n_cmp++;
        if (o_bf_valid !== 1'b1) begin n_bad++; $display("FAIL spot_bfv_c2: got %0d want 1", o_bf_valid); end
      end
      if (c == 4 || c == 44) begin
        n_cmp++;
        if ({o_wr_en, o_wr_addr_A, o_wr_addr_B} !== ((c == 4) ? {1'b1, 4'd0, 4'd1} : {1'b1, 4'd7, 4'd15})) begin
          n_bad++;
          $display("FAIL spot_wr_c%0d: got en=%0d A=%0d B=%0d", c, o_wr_en, o_wr_addr_A, o_wr_addr_B);
        end
      end
      if (c >= 9 && c <= 11) begin
        n_cmp++;
        if (o_rd_en !== 1'b0) begin n_bad++; $display("FAIL spot_drain_c%0d: got rd_en=%0d want 0", c, o_rd_en); end
      end
      if (c == 45) begin
        n_cmp++;
        if ({o_done, o_busy} !== 2'b10) begin
          n_bad++;
          $display("FAIL spot_done_c45: got done=%0d busy=%0d want 1/0", o_done, o_busy);
        end
      end
    end
  endtask

  task automatic test_stage_walk();
    idle_gap();
    check_transform(0, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    idle_gap();
    check_transform(1, 1'b0, 1'b0);
    idle_gap();
    check_transform(2, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    idle_gap();
    check_transform(0, 1'b0, 1'b1);
    check_transform(0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midway();
    idle_gap();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat ($urandom_range(14, 40)) @(negedge clk);
    @(posedge clk);
    #3 i_RST = 1'b0;
    #1;
    n_cmp++;
    if (all_outs !== '0) begin
      n_bad++;
      $display("FAIL midway_reset: got %h want 0", all_outs);
    end
    @(negedge clk);
    i_RST = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({o_wr_en, o_rd_en, o_busy} !== 3'b0) begin
        n_bad++;
        $display("FAIL after_reset %0d: got wr=%0d rd=%0d busy=%0d want 0", i, o_wr_en, o_rd_en, o_busy);
      end
    end
    check_transform(0, 1'b0, 1'b0);
  endtask

  initial begin
    i_RST   = 1'b0;
    i_start = 1'b0;
    build_model();
    test_reset();
    test_spec_points();
    test_stage_walk();
    test_start_ignored();
    test_back_to_back();
    test_reset_midway();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Control and address generator for the in-place radix-2 DIT FFT built around `butterfly_sum`. It walks all `LOG2_N` stages of an N-point transform and issues, each cycle, a butterfly's A/B read addresses to the dual-port sample RAM and a twiddle index to the twiddle ROM. It delays those addresses to match the RAM-plus-butterfly latency and issues the matching write-back addresses for `butterfly_sum`'s `o_A`/`o_B`. Input data in RAM is in bit-reversed order; results land in natural order.

## Interface
- `LOG2_N`, default 4: transform size N = 2^LOG2_N (N ≥ 4).
- `BFLY_LATENCY`, default 2: cycles from `butterfly_sum` inputs to outputs.
- `i_CLK`  in  1  clock, all logic on rising edge.
- `i_RST`  in  1  reset; one clock; asynchronous, active-low.
- `i_start`  in  1  start pulse; sampled only in IDLE.
- `o_busy`  out  1  transform in progress.
- `o_done`  out  1  one-cycle pulse after final write-back.
- `o_stage`  out  LOG2_N  current stage index (0..LOG2_N-1) during ISSUE/DRAIN, else 0.
- `o_rd_en`  out  1  read request to both RAM ports.
- `o_rd_addr_A`, `o_rd_addr_B`  out  LOG2_N each  butterfly operand addresses.
- `o_tw_addr`  out  LOG2_N-1  twiddle ROM index k, selecting W_N^k.
- `o_bf_valid`  out  1  `o_rd_en` delayed 1 cycle; butterfly inputs valid.
- `o_wr_en`  out  1  write-back strobe for both RAM ports.
- `o_wr_addr_A`, `o_wr_addr_B`  out  LOG2_N each  write-back addresses for `o_A` and `o_B`.

## Operation
- RAM is synchronous-read with 1-cycle latency; twiddle ROM likewise. Write-back latency is L = 1 + BFLY_LATENCY.
- States:
  - IDLE: `i_start`=1 → ISSUE with stage=0, k=0.
  - ISSUE: each cycle, issue butterfly k and assert `o_rd_en`. At k = N/2-1 → DRAIN.
  - DRAIN: wait L cycles. Then go to ISSUE with stage+1, or if stage = LOG2_N-1 → DONE.
  - DONE: assert `o_done`, → IDLE.
- Addressing for stage s, butterfly k (0..N/2-1):
  - half = 2^s, j = k mod half, g = k >> s.
  - A = g·2·half + j; B = A + half.
  - tw = j << (LOG2_N-1-s).
  - All quantities are unsigned with no overflow by construction.
- Write path: a shift register of depth L carries {valid, A, B}. `o_wr_en`/`o_wr_addr_*` are its output.
- Address outputs are forced to 0 whenever their enable is low.
- Drain guarantees the last write of stage s occurs before the first read of stage s+1 (no RAW hazard).
- `i_start` is ignored outside IDLE; there is no abort input.
- Reset mid-operation:
  - All state, counters and the delay line clear immediately.
  - No further writes are issued.
  - The next `i_start` begins again at stage 0.

## Timing
- Reset values: every output is 0; state is IDLE.
- `i_start` sampled high at edge cycle 0 → first `o_rd_en` in cycle 1.
- Each stage occupies N/2 issue cycles + L drain cycles. Stage s reads in cycles 1+s·(N/2+L) … s·(N/2+L)+N/2.
- A read in cycle t gives `o_bf_valid` at t+1 and `o_wr_en` at t+L.
- `o_busy` is high from cycle 1 through the cycle of the final write (cycle LOG2_N·(N/2+L)).
- `o_done` is high for exactly the next cycle, with `o_busy` low. For N=16 and L=3, `o_done` is in cycle 45.
- The state is IDLE in the `o_done` cycle: an `i_start` in that cycle is accepted, and the next `o_rd_en` follows one cycle later.
- Throughput: one butterfly per cycle during ISSUE. No gaps within a stage.

## Test plan
- Reset: assert `i_RST`=0 asynchronously mid-cycle → all outputs 0 immediately; hold `i_start`=0 after release → outputs stay 0.
- Stage 0 (N=16, L=3):
  - start at cycle 0 → cycle 1: A=0, B=1, tw=0; cycle 2: A=2, B=3, tw=0.
  - `o_bf_valid` is high in cycle 2.
  - cycle 4: `o_wr_en`=1, wr A=0, B=1.
- Stage 2, k=5 (cycle 1+2·11+5=28) → A=9, B=13, tw=2, `o_stage`=2. Stage 3, k=7 (cycle 41) → A=7, B=15, tw=7.
- Completion:
  - last write in cycle 44 (A=7, B=15);
  - `o_done`=1 and `o_busy`=0 in cycle 45;
  - no `o_rd_en` during cycles 9–11 (drain).
  - Total `o_wr_en` count is 32.
- Start handling:
  - `i_start` held high for cycles 0–20 → only one transform runs.
  - `i_start` in cycle 45 → new `o_rd_en` in cycle 46 with A=0, B=1.
- Reset at cycle 20 → no `o_wr_en` after; restart → stage 0 addresses, `o_done` 45 cycles after the new start.
